// File: rtl/fixed_moving_avg.sv
// fixed_moving_avg: 2-stage valid/ready moving average over N=2**LOG2_N signed samples with round-half-up and saturation; ports clk, rst_n, clear, in_valid/in_ready/in_data, out_valid/out_ready/out_data/out_sat, fill
module fixed_moving_avg #(
  parameter int W = 16,
  parameter int LOG2_N = 2,
  parameter int OUT_W = 16,
  parameter int WARMUP = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W-1:0]     in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat,
  output logic [LOG2_N:0]         fill
);
  localparam int N = 2 ** LOG2_N;
  localparam int SW = W + LOG2_N;
  localparam int PW = LOG2_N > 0 ? LOG2_N : 1;
  localparam logic [LOG2_N:0] NF = (LOG2_N + 1)'(N);
  localparam logic signed [SW:0] RND = (SW + 1)'(N / 2);
  localparam logic signed [W:0] OMAX = {{(W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [W:0] OMIN = ~OMAX;
  logic signed [W-1:0] mem [N];
  logic signed [SW-1:0] sum;
  logic [PW-1:0] wr_ptr;
  logic s1_valid, s1_emit, adv1, adv2, xfer, sat;
  logic signed [W-1:0] old;
  logic signed [SW:0] rs;
  logic signed [W:0] avg;
  logic signed [OUT_W-1:0] res;
  always_comb begin
    adv2 = ~out_valid | out_ready;
    adv1 = ~s1_valid | adv2;
    in_ready = adv1 & rst_n & ~clear;
    xfer = in_valid & in_ready;
    old = fill == NF ? mem[wr_ptr] : '0;
    rs = {sum[SW-1], sum} + RND;
    avg = (W + 1)'(rs >>> LOG2_N);
    sat = avg > OMAX || avg < OMIN;
    res = avg > OMAX ? OMAX[OUT_W-1:0] : avg < OMIN ? OMIN[OUT_W-1:0] : avg[OUT_W-1:0];
  end
  always_ff @(posedge clk)
    if (xfer) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sum <= '0;
      wr_ptr <= '0;
      fill <= '0;
      s1_valid <= 1'b0;
      s1_emit <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_sat <= 1'b0;
    end else begin
      if (xfer) begin
        sum <= sum + SW'(in_data) - SW'(old);
        wr_ptr <= wr_ptr == PW'(N - 1) ? '0 : wr_ptr + 1'b1;
        fill <= fill == NF ? fill : fill + 1'b1;
        s1_emit <= WARMUP == 0 || fill >= NF - 1'b1;
        s1_valid <= 1'b1;
      end else if (adv2) s1_valid <= 1'b0;
      if (adv2) begin
        out_valid <= s1_valid & s1_emit;
        if (s1_valid) begin
          out_data <= res;
          out_sat <= sat;
        end
      end
    end
  end
endmodule

// File: tb/tb_fixed_moving_avg.sv
// tb_fixed_moving_avg: directed checks of the moving average with a 16-bit and an 8-bit output instance
module tb_fixed_moving_avg;
  logic clk = 0, rst_n = 0, clear = 0, in_valid = 0, out_ready = 1;
  logic signed [15:0] in_data = 0;
  logic in_ready, out_valid, out_sat, in_ready8, out_valid8, out_sat8;
  logic signed [15:0] out_data;
  logic signed [7:0] out_data8;
  logic [2:0] fill, fill8;
  int total = 0, bad = 0;
  int qd[$], qs[$], q8d[$], q8s[$];
  always #5 clk = ~clk;
  fixed_moving_avg #(.W(16), .LOG2_N(2), .OUT_W(16), .WARMUP(1)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .fill(fill));
  fixed_moving_avg #(.W(16), .LOG2_N(2), .OUT_W(8), .WARMUP(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready8),
    .in_data(in_data), .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
    .out_sat(out_sat8), .fill(fill8));
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      qd.push_back(int'(out_data));
      qs.push_back(int'(out_sat));
    end
    if (out_valid8 && out_ready) begin
      q8d.push_back(int'(out_data8));
      q8s.push_back(int'(out_sat8));
    end
  end
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic chkq(input string tag, input int got[$], input int exp[$]);
    chk({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), i < got.size() ? got[i] : -999999, exp[i]);
  endtask
  task automatic flush_q();
    qd.delete();
    qs.delete();
    q8d.delete();
    q8s.delete();
  endtask
  task automatic send(input int v);
    logic rd;
    int n;
    in_valid = 1;
    in_data = 16'(v);
    n = 0;
    do begin
      @(negedge clk);
      rd = in_ready;
      @(posedge clk);
      n++;
    end while (!rd && n < 50);
    if (!rd) chk("send_timeout", 0, 1);
    #1 in_valid = 0;
  endtask
  task automatic idle(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask
  task automatic do_clear();
    clear = 1;
    idle(1);
    clear = 0;
  endtask
  initial begin
    idle(2);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_fill", int'(fill), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    rst_n = 1;
    #1 chk("run_in_ready", int'(in_ready), 1);
    flush_q();
    // 1: warm-up, latency and running window
    send(4);
    chk("t1_fill1", int'(fill), 1);
    send(8);
    chk("t1_fill2", int'(fill), 2);
    send(12);
    chk("t1_fill3", int'(fill), 3);
    send(16);
    chk("t1_fill4", int'(fill), 4);
    chk("t1_no_out_yet", int'(out_valid), 0);
    send(20);
    chk("t1_fill_stick", int'(fill), 4);
    chk("t1_lat_valid", int'(out_valid), 1);
    chk("t1_lat_data", int'(out_data), 10);
    idle(3);
    chkq("t1_out", qd, '{10, 14});
    // 2: rounding
    do_clear();
    chk("t2_clr_fill", int'(fill), 0);
    flush_q();
    send(-1); send(-1); send(-1); send(-2);
    idle(3);
    chkq("t2a", qd, '{-1});
    do_clear();
    flush_q();
    send(-2); send(-2); send(-2); send(0);
    idle(3);
    chkq("t2b", qd, '{-1});
    do_clear();
    flush_q();
    send(1); send(1); send(1); send(3);
    idle(3);
    chkq("t2c", qd, '{2});
    // 3: saturation on the 8-bit instance
    do_clear();
    flush_q();
    for (int i = 0; i < 4; i++) send(300);
    for (int i = 0; i < 4; i++) send(-300);
    for (int i = 0; i < 4; i++) send(5);
    idle(3);
    chkq("t3_d8", q8d, '{127, 127, 0, -128, -128, -128, -128, -71, 5});
    chkq("t3_s8", q8s, '{1, 1, 0, 1, 1, 1, 1, 0, 0});
    chkq("t3_d16", qd, '{300, 150, 0, -150, -300, -224, -147, -71, 5});
    chkq("t3_s16", qs, '{0, 0, 0, 0, 0, 0, 0, 0, 0});
    // 4: full-scale extremes
    do_clear();
    flush_q();
    for (int i = 0; i < 4; i++) send(32767);
    for (int i = 0; i < 4; i++) send(-32768);
    idle(3);
    chkq("t4_d", qd, '{32767, 16383, 0, -16384, -32768});
    chkq("t4_s", qs, '{0, 0, 0, 0, 0});
    // 5: backpressure mid-stream
    do_clear();
    flush_q();
    fork
      for (int i = 1; i <= 12; i++) send(i);
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 0;
        idle(1);
        chk("t5_in_ready_low", int'(in_ready), 0);
        chk("t5_hold_data", int'(out_data), 4);
        idle(3);
        chk("t5_hold_data2", int'(out_data), 4);
        chk("t5_hold_valid", int'(out_valid), 1);
        chk("t5_still_blocked", int'(in_ready), 0);
        idle(1);
        out_ready = 1;
      end
    join
    idle(4);
    chkq("t5_out", qd, '{3, 4, 5, 6, 7, 8, 9, 10, 11});
    // 6: clear, then reset, colliding with an offered sample
    do_clear();
    for (int i = 1; i <= 6; i++) send(i * 10);
    in_valid = 1;
    in_data = 99;
    clear = 1;
    idle(1);
    clear = 0;
    in_valid = 0;
    chk("t6_clr_fill", int'(fill), 0);
    chk("t6_clr_valid", int'(out_valid), 0);
    flush_q();
    send(8); send(8); send(8);
    idle(2);
    chk("t6_warm_none", qd.size(), 0);
    send(4);
    idle(3);
    chkq("t6_clr_out", qd, '{7});
    for (int i = 1; i <= 6; i++) send(i * 10);
    in_valid = 1;
    in_data = 99;
    rst_n = 0;
    idle(1);
    rst_n = 1;
    in_valid = 0;
    chk("t6_rst_fill", int'(fill), 0);
    chk("t6_rst_valid", int'(out_valid), 0);
    flush_q();
    send(7); send(7); send(7);
    idle(2);
    chk("t6r_warm_none", qd.size(), 0);
    send(3);
    idle(3);
    chkq("t6_rst_out", qd, '{6});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
